// File: rtl/clock_set_ctrl.sv
// Mode/time-set controller: RUN -> SET_HR -> SET_MIN sequencing, increment strobes
// with hold auto-repeat, set-mode timeout and blinking of the digit pair being set.
module clock_set_ctrl #(
  parameter int repeat_delay_ms = 500,
  parameter int repeat_rate_ms  = 100,
  parameter int blink_half_ms   = 250,
  parameter int timeout_ms      = 10000
) (
  input  logic       CLK100MHZ,
  input  logic       RST,
  input  logic       tick_ms,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       run_en,
  output logic       inc_hr,
  output logic       inc_min,
  output logic       clr_sec,
  output logic [1:0] mode,
  output logic [3:0] digit_blank
);

  localparam int DW = $clog2(repeat_delay_ms + 1);
  localparam int RW = $clog2(repeat_rate_ms + 1);
  localparam int HW = (DW > RW) ? DW : RW;
  localparam int BW = $clog2(blink_half_ms + 1);
  localparam int TW = $clog2(timeout_ms + 1);

  typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2} mode_e;
  typedef enum logic [1:0] {H_IDLE = 2'd0, H_DELAY = 2'd1, H_RATE = 2'd2} hold_e;

  mode_e         mode_q, mode_d;
  hold_e         hold_q, hold_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic          mode_hist_q, inc_hist_q;
  logic          run_en_q, run_en_d;
  logic          inc_hr_q, inc_hr_d;
  logic          inc_min_q, inc_min_d;
  logic          clr_sec_q, clr_sec_d;
  logic [3:0]    blank_q, blank_d;

  logic mode_edge, inc_edge, in_set, to_hit, state_chg, strobe;

  assign mode_edge = btn_mode & ~mode_hist_q;
  assign inc_edge  = btn_inc & ~inc_hist_q;
  assign in_set    = (mode_q != RUN);
  assign to_hit    = in_set && tick_ms && ((to_cnt_q + TW'(1)) == TW'(timeout_ms));
  assign state_chg = (mode_d != mode_q);

  always_ff @(posedge CLK100MHZ) begin
    if (RST) mode_q <= RUN;
    else     mode_q <= mode_d;
  end

  // A mode press always takes priority over the timeout and any increment.
  always_comb begin
    mode_d = mode_q;
    if (mode_edge) begin
      case (mode_q)
        RUN:     mode_d = SET_HR;
        SET_HR:  mode_d = SET_MIN;
        default: mode_d = RUN;
      endcase
    end else if (to_hit) begin
      mode_d = RUN;
    end
  end

  always_comb begin
    hold_d      = hold_q;
    hold_cnt_d  = hold_cnt_q;
    to_cnt_d    = to_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    strobe      = 1'b0;
    if (state_chg) begin
      hold_d      = H_IDLE;
      hold_cnt_d  = '0;
      to_cnt_d    = '0;
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (in_set) begin
      if (inc_edge) begin
        strobe     = 1'b1;
        hold_d     = H_DELAY;
        hold_cnt_d = '0;
      end else if (!btn_inc) begin
        hold_d     = H_IDLE;
        hold_cnt_d = '0;
      end else if (hold_q != H_IDLE && tick_ms) begin
        if ((hold_q == H_DELAY && (hold_cnt_q + HW'(1)) == HW'(repeat_delay_ms)) ||
            (hold_q == H_RATE  && (hold_cnt_q + HW'(1)) == HW'(repeat_rate_ms))) begin
          strobe     = 1'b1;
          hold_d     = H_RATE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      if (inc_edge || strobe) to_cnt_d = '0;
      else if (tick_ms)       to_cnt_d = to_cnt_q + TW'(1);
      // Every increment restarts the blink so the new value is shown at once.
      if (strobe) begin
        blink_cnt_d = '0;
        blink_ph_d  = 1'b0;
      end else if (tick_ms) begin
        if ((blink_cnt_q + BW'(1)) == BW'(blink_half_ms)) begin
          blink_cnt_d = '0;
          blink_ph_d  = ~blink_ph_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BW'(1);
        end
      end
    end
  end

  always_comb begin
    run_en_d  = (mode_d == RUN);
    inc_hr_d  = strobe && (mode_q == SET_HR);
    inc_min_d = strobe && (mode_q == SET_MIN);
    clr_sec_d = (mode_q == SET_MIN) && (mode_d == RUN);
    blank_d   = 4'b0000;
    if (blink_ph_d && mode_d == SET_HR)  blank_d = 4'b1100;
    if (blink_ph_d && mode_d == SET_MIN) blank_d = 4'b0011;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      hold_q      <= H_IDLE;
      hold_cnt_q  <= '0;
      to_cnt_q    <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      mode_hist_q <= 1'b1;
      inc_hist_q  <= 1'b1;
      run_en_q    <= 1'b1;
      inc_hr_q    <= 1'b0;
      inc_min_q   <= 1'b0;
      clr_sec_q   <= 1'b0;
      blank_q     <= 4'b0000;
    end else begin
      hold_q      <= hold_d;
      hold_cnt_q  <= hold_cnt_d;
      to_cnt_q    <= to_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      mode_hist_q <= btn_mode;
      inc_hist_q  <= btn_inc;
      run_en_q    <= run_en_d;
      inc_hr_q    <= inc_hr_d;
      inc_min_q   <= inc_min_d;
      clr_sec_q   <= clr_sec_d;
      blank_q     <= blank_d;
    end
  end

  assign mode        = mode_q;
  assign run_en      = run_en_q;
  assign inc_hr      = inc_hr_q;
  assign inc_min     = inc_min_q;
  assign clr_sec     = clr_sec_q;
  assign digit_blank = blank_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: a tick-counting reference model checked every
// cycle, plus literal expectations taken from the hand-worked scenarios.
module tb_clock_set_ctrl;

  logic       CLK100MHZ, RST, tick_ms, btn_mode, btn_inc;
  logic       run_en, inc_hr, inc_min, clr_sec;
  logic [1:0] mode;
  logic [3:0] digit_blank;

  clock_set_ctrl dut (
    .CLK100MHZ  (CLK100MHZ),
    .RST        (RST),
    .tick_ms    (tick_ms),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .run_en     (run_en),
    .inc_hr     (inc_hr),
    .inc_min    (inc_min),
    .clr_sec    (clr_sec),
    .mode       (mode),
    .digit_blank(digit_blank)
  );

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  int errors = 0;
  int checks = 0;
  int cycle_no = 0;
  int n_hr, n_min, n_clr;

  // Reference model state: elapsed-tick counts since the relevant event.
  int   m_mode, idle_t, hold_t, blink_t;
  bit   hold_on, pm, pi;
  logic [1:0] e_mode;
  logic       e_run, e_hr, e_min, e_clr;
  logic [3:0] e_blank;

  task automatic model_step();
    bit me, ie, strobe, hidden;
    int nm;
    if (RST) begin
      m_mode = 0; pm = 1; pi = 1; hold_on = 0; hold_t = 0; idle_t = 0; blink_t = 0;
      e_mode = 2'd0; e_run = 1; e_hr = 0; e_min = 0; e_clr = 0; e_blank = 4'd0;
    end else begin
      me = btn_mode && !pm;
      ie = btn_inc && !pi;
      strobe = 0;
      nm = m_mode;
      if (me) nm = (m_mode + 1) % 3;
      else if (m_mode != 0 && tick_ms && idle_t + 1 == 10000) nm = 0;
      else if (m_mode != 0) begin
        if (ie) begin strobe = 1; hold_on = 1; hold_t = 0; end
        else if (!btn_inc) hold_on = 0;
        else if (hold_on && tick_ms) begin
          hold_t++;
          if (hold_t >= 500 && (hold_t - 500) % 100 == 0) strobe = 1;
        end
      end
      if (nm != m_mode) begin
        hold_on = 0; idle_t = 0; blink_t = 0;
      end else if (m_mode != 0) begin
        if (ie || strobe) idle_t = 0; else if (tick_ms) idle_t++;
        if (strobe) blink_t = 0; else if (tick_ms) blink_t++;
      end
      e_clr = (m_mode == 2 && nm == 0);
      e_hr  = strobe && m_mode == 1;
      e_min = strobe && m_mode == 2;
      m_mode = nm;
      e_mode = 2'(nm);
      e_run  = (nm == 0);
      hidden = ((blink_t / 250) % 2) == 1;
      e_blank = (nm == 1 && hidden) ? 4'b1100 : (nm == 2 && hidden) ? 4'b0011 : 4'b0000;
      pm = btn_mode;
      pi = btn_inc;
    end
  endtask

  // One clock: update the model at the edge, then compare all outputs 2 ns later.
  task automatic step();
    @(posedge CLK100MHZ);
    model_step();
    #2;
    cycle_no++;
    checks++;
    if ({mode, run_en, inc_hr, inc_min, clr_sec, digit_blank} !==
        {e_mode, e_run, e_hr, e_min, e_clr, e_blank}) begin
      errors++;
      $display("FAIL cycle %0d outputs: got mode=%0d run_en=%0b hr=%0b min=%0b clr=%0b blank=%b, want mode=%0d run_en=%0b hr=%0b min=%0b clr=%0b blank=%b",
               cycle_no, mode, run_en, inc_hr, inc_min, clr_sec, digit_blank,
               e_mode, e_run, e_hr, e_min, e_clr, e_blank);
    end
    n_hr  += int'(inc_hr);
    n_min += int'(inc_min);
    n_clr += int'(clr_sec);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick_ms = 1'b1; step();
      tick_ms = 1'b0; step();
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; step();
    $display("press mode -> mode=%0d run_en=%0b clr_sec=%0b", mode, run_en, clr_sec);
    btn_mode = 1'b0; step();
  endtask

  task automatic clear_counts();
    n_hr = 0; n_min = 0; n_clr = 0;
  endtask

  initial begin
    RST = 1'b1; tick_ms = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    clear_counts();
    step(); step(); step();
    RST = 1'b0; step();
    $display("reset released -> mode=%0d run_en=%0b blank=%b", mode, run_en, digit_blank);
    chk("reset mode", int'(mode), 0);
    chk("reset run_en", int'(run_en), 1);
    chk("reset blank", int'(digit_blank), 0);

    // Mode cycling with a single clr_sec on the SET_MIN -> RUN step.
    clear_counts();
    press_mode(); chk("press1 mode", int'(mode), 1); chk("press1 run_en", int'(run_en), 0);
    press_mode(); chk("press2 mode", int'(mode), 2);
    press_mode(); chk("press3 mode", int'(mode), 0); chk("press3 run_en", int'(run_en), 1);
    chk("cycle clr_sec count", n_clr, 1);

    // SET_MIN hold: strobes at the edge and at hold ticks 500, 600, 700.
    press_mode(); press_mode();
    clear_counts();
    btn_inc = 1'b1; step();
    $display("inc edge in SET_MIN -> inc_min=%0b", inc_min);
    chk("hold first strobe", int'(inc_min), 1);
    tick_n(750);
    btn_inc = 1'b0; step();
    $display("hold 750 ticks -> inc_min pulses=%0d inc_hr pulses=%0d", n_min, n_hr);
    chk("hold inc_min count", n_min, 4);
    chk("hold inc_hr count", n_hr, 0);
    chk("hold mode", int'(mode), 2);

    // Timeout from SET_HR (no clr_sec) and from SET_MIN (clr_sec once).
    press_mode(); press_mode();
    clear_counts();
    tick_n(9999);
    chk("to_hr before limit", int'(mode), 1);
    tick_ms = 1'b1; step(); tick_ms = 1'b0;
    $display("SET_HR timeout tick -> mode=%0d clr_sec=%0b", mode, clr_sec);
    chk("to_hr mode", int'(mode), 0);
    chk("to_hr clr_sec count", n_clr, 0);
    step();
    press_mode(); press_mode();
    clear_counts();
    tick_n(9999);
    chk("to_min before limit", int'(mode), 2);
    tick_ms = 1'b1; step(); tick_ms = 1'b0;
    $display("SET_MIN timeout tick -> mode=%0d clr_sec=%0b", mode, clr_sec);
    chk("to_min mode", int'(mode), 0);
    chk("to_min clr_sec", int'(clr_sec), 1);
    step();
    chk("to_min clr_sec count", n_clr, 1);

    // Blink in SET_HR, restarted by an increment.
    press_mode();
    tick_n(249); chk("blink 249", int'(digit_blank), 0);
    tick_n(1);   chk("blink 250", int'(digit_blank), 12);
    tick_n(250); chk("blink 500", int'(digit_blank), 0);
    tick_n(250); chk("blink 750", int'(digit_blank), 12);
    btn_inc = 1'b1; step();
    $display("inc press while hidden -> inc_hr=%0b blank=%b", inc_hr, digit_blank);
    chk("blink inc strobe", int'(inc_hr), 1);
    chk("blink inc visible", int'(digit_blank), 0);
    btn_inc = 1'b0; step();
    tick_n(249); chk("blink post-inc 249", int'(digit_blank), 0);
    tick_n(1);   chk("blink post-inc 250", int'(digit_blank), 12);

    // Simultaneous mode and inc edges: mode wins, no strobe.
    btn_mode = 1'b1; btn_inc = 1'b1; step();
    $display("mode+inc together -> mode=%0d inc_hr=%0b inc_min=%0b", mode, inc_hr, inc_min);
    chk("simul mode", int'(mode), 2);
    chk("simul inc_hr", int'(inc_hr), 0);
    chk("simul inc_min", int'(inc_min), 0);
    btn_mode = 1'b0; btn_inc = 1'b0; step();
    press_mode();
    clear_counts();
    for (int k = 0; k < 3; k++) begin
      btn_inc = 1'b1; step(); tick_n(3);
      btn_inc = 1'b0; step();
    end
    $display("inc presses in RUN -> strobes=%0d", n_hr + n_min);
    chk("run inc strobes", n_hr + n_min, 0);

    // btn_inc held through reset release, then reset mid-repeat.
    btn_inc = 1'b1; RST = 1'b1; step(); step();
    RST = 1'b0; step();
    press_mode();
    clear_counts();
    tick_n(600);
    chk("held-through-reset strobes", n_hr, 0);
    btn_inc = 1'b0; step();
    btn_inc = 1'b1; step();
    chk("fresh edge strobe", int'(inc_hr), 1);
    clear_counts();
    tick_n(599);
    chk("repeat before reset", n_hr, 1);
    tick_ms = 1'b1; RST = 1'b1; step();
    $display("reset mid-repeat -> mode=%0d run_en=%0b inc_hr=%0b blank=%b", mode, run_en, inc_hr, digit_blank);
    chk("rst mid mode", int'(mode), 0);
    chk("rst mid run_en", int'(run_en), 1);
    chk("rst mid inc_hr", int'(inc_hr), 0);
    chk("rst mid blank", int'(digit_blank), 0);
    tick_ms = 1'b0; RST = 1'b0; step(); step();
    chk("after rst mode", int'(mode), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
